// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one data-memory port between the pipeline and DMA/debug.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin tie-break (default: pipeline wins ties).
module mem_port_arbiter (
  input  logic        clk,
  input  logic        rst,
  input  logic        p_req,
  input  logic        p_we,
  input  logic [1:0]  p_size,
  input  logic [63:0] p_addr,
  input  logic [63:0] p_wdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [1:0]  d_size,
  input  logic [63:0] d_addr,
  input  logic [63:0] d_wdata,
  output logic        p_done,
  output logic        d_done,
  output logic [63:0] p_rdata,
  output logic [63:0] d_rdata,
  output logic        p_stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [1:0]  mem_size,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic        mem_ready,
  input  logic [63:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY_P, BUSY_D, RESP} state_t;

  state_t      state_q, state_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [1:0]  mem_size_q, mem_size_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
  logic        p_done_q, p_done_d;
  logic        d_done_q, d_done_d;
  logic [63:0] p_rdata_q, p_rdata_d;
  logic [63:0] d_rdata_q, d_rdata_d;
  logic        grant_dma;
  logic        any_req;

  assign any_req = p_req | d_req;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_dma_q, last_dma_d;

  // On a tie, the side that did not win last time gets the port.
  assign grant_dma = d_req & (~p_req | ~last_dma_q);

  always_comb begin
    last_dma_d = last_dma_q;
    if (state_q == IDLE && any_req)
      last_dma_d = grant_dma;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_dma_q <= 1'b0;
    else     last_dma_q <= last_dma_d;
  end
`else
  assign grant_dma = d_req & ~p_req;
`endif

  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_size_d  = mem_size_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    p_done_d    = 1'b0;
    d_done_d    = 1'b0;
    p_rdata_d   = p_rdata_q;
    d_rdata_d   = d_rdata_q;
    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          mem_req_d = 1'b1;
          if (grant_dma) begin
            state_d     = BUSY_D;
            mem_we_d    = d_we;
            mem_size_d  = d_size;
            mem_addr_d  = d_addr;
            mem_wdata_d = d_wdata;
          end else begin
            state_d     = BUSY_P;
            mem_we_d    = p_we;
            mem_size_d  = p_size;
            mem_addr_d  = p_addr;
            mem_wdata_d = p_wdata;
          end
        end
      end
      BUSY_P: begin
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          p_done_d  = 1'b1;
          p_rdata_d = mem_rdata;
        end
      end
      BUSY_D: begin
        if (mem_ready) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          d_done_d  = 1'b1;
          d_rdata_d = mem_rdata;
        end
      end
      RESP: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_size_q  <= 2'b00;
      mem_addr_q  <= 64'd0;
      mem_wdata_q <= 64'd0;
      p_done_q    <= 1'b0;
      d_done_q    <= 1'b0;
      p_rdata_q   <= 64'd0;
      d_rdata_q   <= 64'd0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_size_q  <= mem_size_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      p_done_q    <= p_done_d;
      d_done_q    <= d_done_d;
      p_rdata_q   <= p_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_size  = mem_size_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign p_done    = p_done_q;
  assign d_done    = d_done_q;
  assign p_rdata   = p_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign p_stall   = p_req & ~p_done_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized transaction-level checks of mem_port_arbiter.
// Expected timing comes from the latency rule: done at cycle 2+waits after request.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p_req = 0, p_we = 0;
  logic [1:0]  p_size = 0;
  logic [63:0] p_addr = 0, p_wdata = 0;
  logic        d_req = 0, d_we = 0;
  logic [1:0]  d_size = 0;
  logic [63:0] d_addr = 0, d_wdata = 0;
  logic        p_done, d_done, p_stall;
  logic [63:0] p_rdata, d_rdata;
  logic        mem_req, mem_we;
  logic [1:0]  mem_size;
  logic [63:0] mem_addr, mem_wdata;
  logic        mem_ready = 0;
  logic [63:0] mem_rdata = 0;

  int checks = 0;
  int errors = 0;

  logic [63:0] exp_p_rdata = 0;
  logic [63:0] exp_d_rdata = 0;
  bit          last_dma = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .p_req(p_req), .p_we(p_we), .p_size(p_size),
    .p_addr(p_addr), .p_wdata(p_wdata),
    .d_req(d_req), .d_we(d_we), .d_size(d_size),
    .d_addr(d_addr), .d_wdata(d_wdata),
    .p_done(p_done), .d_done(d_done),
    .p_rdata(p_rdata), .d_rdata(d_rdata),
    .p_stall(p_stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  task automatic test_reset();
    rst = 1'b1;
    p_req = 1'b1;
    mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({mem_req, mem_we, mem_size, p_done, d_done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {mem_req, mem_we, mem_size, p_done, d_done});
    end
    checks++;
    if ({mem_addr, mem_wdata, p_rdata, d_rdata} !== 256'd0) begin
      errors++;
      $display("FAIL reset_data got %h %h %h %h want 0",
               mem_addr, mem_wdata, p_rdata, d_rdata);
    end
    checks++;
    if (p_stall !== 1'b1) begin
      errors++;
      $display("FAIL reset_stall got %b want 1", p_stall);
    end
    @(posedge clk); #1;
    p_req = 1'b0;
    mem_ready = 1'b0;
    rst = 1'b0;
    exp_p_rdata = 0;
    exp_d_rdata = 0;
    last_dma = 0;
  endtask

  // One lone-requester transaction; memory answers after `waits` wait cycles.
  task automatic do_txn(input bit isd, input bit we, input logic [1:0] sz,
                        input logic [63:0] a, input logic [63:0] wd,
                        input int waits, input logic [63:0] rd,
                        input bit noise);
    int  done_c;
    bit  busy, e_pd, e_dd;
    done_c = waits + 2;
    @(posedge clk); #1;
    if (isd) begin
      d_req = 1; d_we = we; d_size = sz; d_addr = a; d_wdata = wd;
    end else begin
      p_req = 1; p_we = we; p_size = sz; p_addr = a; p_wdata = wd;
    end
    mem_ready = noise;
    mem_rdata = {$urandom, $urandom};
    for (int c = 0; c <= done_c + 1; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        mem_ready = (c == waits + 1) || (noise && c >= done_c);
        mem_rdata = (c == waits + 1) ? rd : {$urandom, $urandom};
        if (noise && c <= done_c) begin
          if (isd) begin
            d_addr = a ^ 64'h60; d_wdata = ~wd; d_we = ~we; d_size = ~sz;
          end else begin
            p_addr = a ^ 64'h60; p_wdata = ~wd; p_we = ~we; p_size = ~sz;
          end
        end
        if (c == done_c + 1) begin
          p_req = 0;
          d_req = 0;
        end
      end
      if (c == 1) last_dma = isd;
      busy = (c >= 1) && (c <= waits + 1);
      e_pd = !isd && (c == done_c);
      e_dd = isd && (c == done_c);
      if (c == done_c) begin
        if (isd) exp_d_rdata = rd;
        else     exp_p_rdata = rd;
      end
      @(negedge clk);
      checks++;
      if (mem_req !== busy) begin
        errors++;
        $display("FAIL txn_mem_req c=%0d got %b want %b", c, mem_req, busy);
      end
      if (busy) begin
        checks++;
        if ({mem_we, mem_size, mem_addr, mem_wdata} !== {we, sz, a, wd}) begin
          errors++;
          $display("FAIL txn_cmd c=%0d got %b %b %h %h want %b %b %h %h",
                   c, mem_we, mem_size, mem_addr, mem_wdata, we, sz, a, wd);
        end
      end
      checks++;
      if ({p_done, d_done} !== {e_pd, e_dd}) begin
        errors++;
        $display("FAIL txn_done c=%0d got %b%b want %b%b",
                 c, p_done, d_done, e_pd, e_dd);
      end
      checks++;
      if (p_stall !== (p_req && !e_pd)) begin
        errors++;
        $display("FAIL txn_stall c=%0d got %b want %b",
                 c, p_stall, p_req && !e_pd);
      end
      if (c == done_c || !isd) begin
        checks++;
        if (d_rdata !== exp_d_rdata) begin
          errors++;
          $display("FAIL txn_d_rdata c=%0d got %h want %h", c, d_rdata, exp_d_rdata);
        end
      end
      if (c == done_c || isd) begin
        checks++;
        if (p_rdata !== exp_p_rdata) begin
          errors++;
          $display("FAIL txn_p_rdata c=%0d got %h want %h", c, p_rdata, exp_p_rdata);
        end
      end
    end
    mem_ready = 0;
  endtask

  task automatic test_pipe_store();
    do_txn(0, 1, 2'b00, 64'h10, 64'hAA, 0, 64'h5555, 0);
  endtask

  task automatic test_dma_load_wait();
    do_txn(1, 0, 2'b10, 64'h30, 64'h0, 4, 64'hAABBCCDD, 0);
  endtask

  task automatic test_addr_hold();
    do_txn(0, 0, 2'b11, 64'h20, 64'h1234, 3, 64'hFEED, 1);
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      do_txn(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
             2'($urandom_range(3, 0)), {$urandom, $urandom},
             {$urandom, $urandom}, int'($urandom_range(4, 0)),
             {$urandom, $urandom}, 1'($urandom_range(1, 0)));
    end
  endtask

  // Both requesters held high: three back-to-back grants.
  task automatic test_back_to_back_tie();
    bit w;
    logic [63:0] rd;
    do_txn(1, 0, 2'b01, 64'h88, 64'h0, 0, 64'h77, 0);
    @(posedge clk); #1;
    p_req = 1; p_we = 0; p_size = 2'b11; p_addr = 64'h100; p_wdata = 64'h1;
    d_req = 1; d_we = 1; d_size = 2'b10; d_addr = 64'h200; d_wdata = 64'h2;
    for (int r = 0; r < 3; r++) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w = !last_dma;
`else
      w = 1'b0;
`endif
      rd = 64'h1000 + 64'(r);
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0) begin
        errors++;
        $display("FAIL tie_gap r=%0d got %b want 0", r, mem_req);
      end
      @(posedge clk); #1;
      mem_ready = 1; mem_rdata = rd;
      @(negedge clk);
      checks++;
      if ({mem_req, mem_addr} !== {1'b1, (w ? 64'h200 : 64'h100)}) begin
        errors++;
        $display("FAIL tie_grant r=%0d got %b %h want 1 %h",
                 r, mem_req, mem_addr, (w ? 64'h200 : 64'h100));
      end
      @(posedge clk); #1;
      mem_ready = 0;
      last_dma = w;
      if (w) exp_d_rdata = rd;
      else   exp_p_rdata = rd;
      @(negedge clk);
      checks++;
      if ({p_done, d_done, p_rdata, d_rdata} !==
          {!w, w, exp_p_rdata, exp_d_rdata}) begin
        errors++;
        $display("FAIL tie_done r=%0d got %b%b %h %h want %b%b %h %h",
                 r, p_done, d_done, p_rdata, d_rdata,
                 !w, w, exp_p_rdata, exp_d_rdata);
      end
      @(posedge clk); #1;
      if (r == 2) begin
        p_req = 0;
        d_req = 0;
      end
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    d_req = 1; d_we = 1; d_size = 2'b11; d_addr = 64'h30; d_wdata = 64'h99;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_busy got %b want 1", mem_req);
    end
    #1;
    rst = 1; p_req = 1;
    #1;
    exp_p_rdata = 0;
    exp_d_rdata = 0;
    last_dma = 0;
    checks++;
    if ({mem_req, mem_we, mem_size, mem_addr, mem_wdata, p_done, d_done,
         p_rdata, d_rdata, p_stall} !== {134'd0, 128'd0, 1'b1}) begin
      errors++;
      $display("FAIL rstmid_async got %b %b %b %h %h %b%b %h %h %b want zeros stall 1",
               mem_req, mem_we, mem_size, mem_addr, mem_wdata, p_done, d_done,
               p_rdata, d_rdata, p_stall);
    end
    @(posedge clk); #1;
    rst = 0; p_req = 0; d_req = 0;
    @(posedge clk); #1;
    mem_ready = 1; mem_rdata = 64'hDEAD;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++;
      if ({mem_req, p_done, d_done, mem_addr, d_rdata} !== 131'd0) begin
        errors++;
        $display("FAIL rstmid_after c=%0d got %b %b%b %h %h want 0",
                 c, mem_req, p_done, d_done, mem_addr, d_rdata);
      end
      @(posedge clk); #1;
      mem_ready = 0;
    end
    do_txn(0, 0, 2'b01, 64'h48, 64'h0, 1, 64'hC0DE, 0);
  endtask

  initial begin
    test_reset();
    test_pipe_store();
    test_dma_load_wait();
    test_addr_hold();
    test_random();
    test_back_to_back_tie();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock, all state updates on rising edge.
REQ-002 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-003 SHALL have ports: p_req  input  1 / p_we  input  1 / p_size  input  2 / p_addr  input  64 / p_wdata  input  64  pipeline MEM-stage request; size codes 00 byte, 01 half, 10 word, 11 double.
REQ-004 SHALL have ports: d_req, d_we, d_size, d_addr, d_wdata  input  1/1/2/64/64  DMA/debug request, same encoding.
REQ-005 SHALL have ports: p_done, d_done  output  1  one-cycle completion pulses; p_rdata, d_rdata  output  64  read data, valid while the matching done is high.
REQ-006 SHALL have port: p_stall  output  1  pipeline hold; equals p_req AND NOT p_done.
REQ-007 SHALL have ports: mem_req  output  1 / mem_we  output  1 / mem_size  output  2 / mem_addr  output  64 / mem_wdata  output  64  single-ported data-memory command.
REQ-008 SHALL have ports: mem_ready  input  1 / mem_rdata  input  64  memory completion pulse and read data, valid together.

Function
REQ-009 SHALL implement FSM states IDLE, BUSY_P, BUSY_D, RESP.
REQ-010 In IDLE, on a rising edge with any req high, SHALL select a winner, capture its we/size/addr/wdata into command registers and move to BUSY_P or BUSY_D.
REQ-011 Winner without CONFIG macro: pipeline always wins a tie.
REQ-012 In BUSY_x, mem_req SHALL be 1 and mem_we/size/addr/wdata SHALL come from the command registers; the requester's inputs may change without effect.
REQ-013 In BUSY_x, on an edge with mem_ready=1, SHALL capture mem_rdata into x_rdata (write: capture anyway) and move to RESP, recording owner x.
REQ-014 In RESP, x_done SHALL be 1 for exactly that cycle, mem_req SHALL be 0, and all requests SHALL be ignored; next state IDLE.
REQ-015 A req still high in the first IDLE cycle after RESP SHALL be treated as a new transaction (back-to-back allowed).
REQ-016 Minimum latency, req sampled to done: 3 cycles (grant edge, mem_ready edge, done cycle); each mem_ready wait cycle adds one.
REQ-017 mem_ready while IDLE or RESP SHALL be ignored.
REQ-018 The non-owner's done SHALL stay 0; its rdata SHALL hold its last value.
REQ-019 At most one transaction SHALL be outstanding; the memory never sees mem_req high in two consecutive transactions without an intervening low cycle.

Reset
REQ-020 rst high SHALL asynchronously force state IDLE, mem_req 0, mem_we 0, mem_size 00, mem_addr 0, mem_wdata 0, p_done 0, d_done 0, p_rdata 0, d_rdata 0, and the priority pointer to pipeline.
REQ-021 Reset mid-transaction SHALL abandon it; no done pulse SHALL follow, and a late mem_ready SHALL be ignored.
REQ-022 p_stall SHALL follow REQ-006 during reset (p_req high gives p_stall high).

Configuration
REQ-023 Macro MEM_ARB_ROUND_ROBIN_EN, when defined, SHALL add a last-granted register (reset value pipeline), updated on each grant.
REQ-024 With the macro defined, on a tie SHALL grant the requester not last granted; a lone requester always wins.
REQ-025 Without the macro, there SHALL be no pointer register and fixed pipeline priority applies.

Verification
REQ-026 Pipeline store: p_req=1, p_we=1, p_size=00, p_addr=0x10, p_wdata=0xAA, mem_ready in first BUSY cycle -> mem_req high 1 cycle with addr 0x10, data 0xAA; p_done pulses 3rd cycle; p_stall low in the done cycle.
REQ-027 DMA load with 4 wait cycles: d_req, addr 0x30, mem_rdata=0xAABBCCDD on mem_ready -> d_done after 7 cycles, d_rdata=0xAABBCCDD; p_* untouched.
REQ-028 Simultaneous p_req/d_req held high, macro off -> three consecutive pipeline grants, DMA starved; macro on -> grants alternate P, D, P.
REQ-029 Change p_addr from 0x20 to 0x40 during BUSY_P -> mem_addr stays 0x20 until done.
REQ-030 Assert rst during BUSY_D, then pulse mem_ready after release -> all outputs reset, no d_done, state IDLE.
